// File: rtl/code_receiver.sv
// code_receiver: serial code receiver for a 1-start / 8-data (MSB first) / 1-stop frame.
// The line idles low. The start bit is 1 and the stop bit is 0.
// Optional build macro CODE_RECEIVER_MAJORITY_EN: each bit decision becomes the
// 2-of-3 majority of the synchronized line around the nominal sample tick.
module code_receiver #(
    parameter int unsigned BIT_TICKS = 12500
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = $clog2(BIT_TICKS);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    localparam logic [TW-1:0] BitLast = TW'(BIT_TICKS - 1);
`ifdef CODE_RECEIVER_MAJORITY_EN
    // The decision lands one tick after the nominal point. The tick counter is cleared
    // one cycle late on leaving START, so data/stop decisions still fall on BitLast.
    localparam logic [TW-1:0] StartDec = TW'(BIT_TICKS / 2);
`else
    localparam logic [TW-1:0] StartDec = TW'(BIT_TICKS / 2 - 1);
`endif

    logic          sync_q;
    logic          rx_s;
    logic          rx_d;
`ifdef CODE_RECEIVER_MAJORITY_EN
    logic          rx_d2;
`endif
    logic          sample;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

`ifdef CODE_RECEIVER_MAJORITY_EN
    // Majority vote of the line at the nominal tick and at the ticks on each side of it.
    always_comb begin
        sample = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
    end
`else
    // Single sample of the synchronized line at the nominal tick.
    always_comb begin
        sample = rx_s;
    end
`endif

    // Next-state logic for the frame FSM, counters, shift register and output pulses.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // Only a 0->1 edge starts a frame, so a line held high never retriggers.
                if (rx_s && !rx_d) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (tick_q == StartDec) begin
                    tick_d = '0;
                    bit_d  = '0;
                    state_d = sample ? StData : StIdle;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StData: begin
                if (tick_q == BitLast) begin
                    tick_d  = '0;
                    shift_d = {shift_q[6:0], sample};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            StStop: begin
                if (tick_q == BitLast) begin
                    tick_d  = '0;
                    state_d = StIdle;
                    if (!sample) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    // Synchronizer, edge-detect history and all FSM state with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q  <= 1'b0;
            rx_s    <= 1'b0;
            rx_d    <= 1'b0;
`ifdef CODE_RECEIVER_MAJORITY_EN
            rx_d2   <= 1'b0;
`endif
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= rx_in;
            rx_s    <= sync_q;
            rx_d    <= rx_s;
`ifdef CODE_RECEIVER_MAJORITY_EN
            rx_d2   <= rx_d;
`endif
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Registered outputs; busy is decoded directly from the state.
    always_comb begin
        code       = code_q;
        code_valid = valid_q;
        frame_err  = err_q;
        busy       = (state_q != StIdle);
    end

endmodule

// File: doc/code_receiver.md
CODE_RECEIVER -- requirements
Module: code_receiver

Interface
REQ-001 Parameter BIT_TICKS, default 12500, CLOCK_50 cycles per serial bit (4 kHz line rate); legal values are even and >= 4.
REQ-002 CLOCK_50  input  1  sole clock, 50 MHz; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_in  input  1  asynchronous serial line from the transmitter GPIO pin; idle level 0.
REQ-005 code  output  8  last correctly framed received code, held until the next good frame.
REQ-006 code_valid  output  1  one-cycle pulse when code updates.
REQ-007 frame_err  output  1  one-cycle pulse when a frame's stop bit is 1.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 rx_in passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s plus a 1-cycle delayed copy rx_d.
REQ-010 Frame format: start bit 1, 8 data bits MSB first, stop bit 0; each bit lasts BIT_TICKS cycles.
REQ-011 States: IDLE, START, DATA, STOP; encoding is free.
REQ-012 IDLE: a rising edge (rx_s=1, rx_d=0) moves to START and clears the tick counter; a constant 1 level never starts a frame.
REQ-013 START: at tick BIT_TICKS/2-1, rx_s is sampled; 1 -> DATA with tick counter and bit counter cleared; 0 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at tick BIT_TICKS-1 (mid-bit), the sampled bit shifts into an 8-bit register from the LSB end (first bit ends as code[7]); the tick counter wraps to 0; after the 8th sample -> STOP.
REQ-015 STOP: at tick BIT_TICKS-1, sample 0 -> code <= shift register and code_valid=1 for that cycle; sample 1 -> frame_err=1 for that cycle and code unchanged; both cases -> IDLE.
REQ-016 code_valid and frame_err are never high together and are never high for more than one consecutive cycle.
REQ-017 Latency: code_valid asserts 9.5*BIT_TICKS + 3 cycles (+/-1) after the rx_in rising edge of the start bit.
REQ-018 A frame ending with stop bit 1 followed by a held-high line must not re-trigger until rx_s has been 0 for at least one cycle.
REQ-019 rx_in changes during DATA between sample points have no effect.
REQ-020 Tick counter width is $clog2(BIT_TICKS); no overflow past BIT_TICKS-1.

Reset
REQ-021 On reset=1 at a clock edge: state=IDLE, counters=0, shift register=0, code=8'h00, code_valid=0, frame_err=0, busy=0, both synchronizer flops=0.
REQ-022 Reset mid-frame aborts the frame with no output pulse; reception restarts only on a new rising edge after reset deasserts.

Configuration
REQ-023 Macro CODE_RECEIVER_MAJORITY_EN: when defined, each sample in START, DATA, and STOP is the 2-of-3 majority of rx_s at ticks T-1, T, and T+1 around the nominal sample tick T, and the decision is made at T+1; when undefined, the single sample at T is used, as stated above.
REQ-024 With the macro defined, BIT_TICKS >= 6 is required, and the latency in REQ-017 increases by 1 cycle.

Verification (BIT_TICKS=16)
REQ-025 Send frame with data 8'hA5, stop 0 -> one code_valid pulse, code=8'hA5, frame_err never high.
REQ-026 Send 8'h3C then 8'hFF back-to-back (start follows stop immediately) -> two code_valid pulses, code=8'h3C then 8'hFF.
REQ-027 Send 8'h5A with stop bit 1, then hold rx_in=1 for 64 cycles -> one frame_err pulse, code keeps its prior value, busy=0 after the frame, no new frame starts.
REQ-028 Apply a 3-cycle high glitch on an idle line -> START rejects it, returns to IDLE, no pulses; a following 8'h81 frame is received correctly.
REQ-029 Assert reset for 1 cycle mid-way through the DATA bits of 8'hC3 -> outputs return to reset values, no code_valid; the next 8'h12 frame is received correctly.
REQ-030 With CODE_RECEIVER_MAJORITY_EN defined, inject a 1-cycle inversion at each nominal sample tick of 8'h96 -> code=8'h96 with code_valid asserted; the same stimulus with the macro undefined -> code=8'h69, or frame_err.
